alu_rr_scheduler: RTL and testbench
===================================

// Module: alu_rr_scheduler
// PURPOSE
// - Shares one registered 4-bit ALU (A/B/Op in, 8-bit Result out, 1-clk latency) among NUM_REQ requesters.
// - Round-robin arbitration, one op in flight, tagged response with backpressure.
// - Sits between requesting engines and the ALU instance; sole driver of the ALU's A, B and Op inputs.
// PARAMETERS
// - NUM_REQ  4  number of requesters (2..8); ID width IDW = $clog2(NUM_REQ)
// - DATA_W   4  operand width; must match ALU A/B
// - RES_W    8  result width; must match ALU Result
// PORTS
// - clk         in   1              single clock; all logic on posedge
// - reset       in   1              synchronous, active-high reset
// - req_valid   in   NUM_REQ        per-requester op request
// - req_ready   out  NUM_REQ        one-hot accept; combinational, only in IDLE
// - req_a       in   NUM_REQ*DATA_W operand A, slice i = requester i
// - req_b       in   NUM_REQ*DATA_W operand B
// - req_op      in   NUM_REQ*2      0 add, 1 sub, 2 mul, 3 div
// - alu_a       out  DATA_W         registered, to ALU A
// - alu_b       out  DATA_W         registered, to ALU B
// - alu_op      out  2              registered, to ALU Op
// - alu_result  in   RES_W          from ALU Result
// - rsp_valid   out  1              response valid, held until rsp_ready
// - rsp_ready   in   1              response consumer ready
// - rsp_id      out  IDW            requester index of response
// - rsp_result  out  RES_W          result, passed unmodified from ALU
// - rsp_err     out  1              divide-by-zero flag (guard feature only)
// - busy        out  1              high in any state other than IDLE
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, RR pointer 0. Reset mid-op drops the in-flight op; no response issued.
// - FSM IDLE -> EXEC -> CAPT -> RESP -> IDLE.
// - IDLE: grant = first req_valid[i] searching from ptr upward with wrap; req_ready[grant] = 1 that cycle.
//   - On grant: latch that requester's a/b/op into alu_*, rsp_id <= i, ptr <= (i+1) mod NUM_REQ, go to EXEC.
//   - No valid requests: stay in IDLE; alu_* hold their last value.
// - EXEC: ALU samples alu_* at this edge; go to CAPT.
// - CAPT: rsp_result <= alu_result; rsp_valid <= 1; go to RESP.
// - RESP: hold rsp_* stable while !rsp_ready. rsp_valid && rsp_ready -> rsp_valid <= 0, go to IDLE.
// - Latency: accept in cycle n -> rsp_valid high from cycle n+3. Minimum 4 cycles per op; no new grant until IDLE.
// - Requesters hold req_* stable until their req_ready. Requests pending during busy wait; none is lost.
// - Arithmetic is the ALU's, 8-bit context; no saturation. Sub underflow wraps (3-5 = 8'hFE). Div truncates.
// - Grants are fair: every requester continuously asserting valid is served within NUM_REQ grants.
// CONFIGURATION
// - ALU_DIV0_GUARD_EN defined:
//   - Accepted op==3 with b==0: alu_op <= 0 and alu_a/alu_b <= 0, so the ALU never divides by zero.
//   - Response carries rsp_result = 8'hFF and rsp_err = 1, with the same latency as a normal op.
// - ALU_DIV0_GUARD_EN undefined: no detection; rsp_err tied to 0; ALU output passed as-is (X in simulation).
// TESTING
// - Single req0 A=3 B=5 Op=0 -> req_ready[0] 1 clk; rsp_valid at accept+3; rsp_id=0, rsp_result=8'h08.
// - All 4 valid continuously, Op=2 A=15 B=15 -> grant order 0,1,2,3,0; each rsp_result=8'hE1; one op per 4 clks.
// - req2 A=3 B=5 Op=1 with rsp_ready low 5 clks -> rsp_valid/rsp_result=8'hFE/rsp_id=2 stable; no grants until handshake.
// - req1 A=9 B=0 Op=3 with guard on -> alu_op=0, rsp_result=8'hFF, rsp_err=1; guard off -> rsp_err=0.
// - reset pulsed in EXEC -> next clk all outputs 0, state IDLE, no response; pending req0 granted first afterwards.
// - req3 and req1 valid with ptr=2 -> req3 granted first, then req1; ptr ends at 2.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered ALU among NUM_REQ requesters, with one op in flight.
// Define ALU_DIV0_GUARD_EN to intercept divide-by-zero (rsp_result=FF, rsp_err=1); otherwise rsp_err is 0.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int RES_W   = 8,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [1:0]                alu_op,
  input  logic [RES_W-1:0]          alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [RES_W-1:0]          rsp_result,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]  rsp_result_q, rsp_result_d;

  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [1:0]        sel_op;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin : grant_search
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
        sel_op = req_op[i*2 +: 2];
        req_ready[i] = (state_q == ST_IDLE) && grant_found && !reset;
      end
    end
  end

`ifdef ALU_DIV0_GUARD_EN
  logic sel_div0;
  logic err_pend_q, err_pend_d;
  logic rsp_err_q, rsp_err_d;
  assign sel_div0 = (sel_op == 2'd3) && (sel_b == '0);
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
`ifdef ALU_DIV0_GUARD_EN
    err_pend_d   = err_pend_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          rsp_id_d = grant_idx;
          ptr_d    = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
          state_d  = ST_EXEC;
`ifdef ALU_DIV0_GUARD_EN
          // Feed the ALU a harmless add so it never sees a zero divisor.
          err_pend_d = sel_div0;
          if (sel_div0) begin
            alu_a_d  = '0;
            alu_b_d  = '0;
            alu_op_d = 2'd0;
          end
`endif
        end
      end
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: begin
        rsp_result_d = alu_result;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
`ifdef ALU_DIV0_GUARD_EN
        rsp_err_d = err_pend_q;
        if (err_pend_q) rsp_result_d = {RES_W{1'b1}};
`endif
      end
      default: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
`ifdef ALU_DIV0_GUARD_EN
      err_pend_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
`ifdef ALU_DIV0_GUARD_EN
      err_pend_q   <= err_pend_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef ALU_DIV0_GUARD_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed testbench for alu_rr_scheduler with a behavioural registered ALU attached.
// Guard-dependent expectations follow ALU_DIV0_GUARD_EN.
module tb_alu_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;
  localparam int RES_W   = 8;
  localparam int IDW     = 2;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a = '0;
  logic [NUM_REQ*DATA_W-1:0] req_b = '0;
  logic [NUM_REQ*2-1:0]      req_op = '0;
  logic [DATA_W-1:0]         alu_a, alu_b;
  logic [1:0]                alu_op;
  logic [RES_W-1:0]          alu_result = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [IDW-1:0]            rsp_id;
  logic [RES_W-1:0]          rsp_result;
  logic                      rsp_err;
  logic                      busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  // Registered ALU model: one clock from operands to result, 8-bit arithmetic.
  always @(posedge clk) begin
    case (alu_op)
      2'd0: alu_result <= {4'h0, alu_a} + {4'h0, alu_b};
      2'd1: alu_result <= {4'h0, alu_a} - {4'h0, alu_b};
      2'd2: alu_result <= {4'h0, alu_a} * {4'h0, alu_b};
      default: alu_result <= (alu_b == 4'h0) ? 8'hxx : {4'h0, alu_a} / {4'h0, alu_b};
    endcase
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    req_valid[i]      = 1'b1;
    req_a[i*4 +: 4]   = a;
    req_b[i*4 +: 4]   = b;
    req_op[i*2 +: 2]  = op;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    checks++; if ({alu_a, alu_b, alu_op} !== 10'h0) begin errors++; $display("[TB] FAIL reset_alu: got %0h expected 0", {alu_a, alu_b, alu_op}); end
    checks++; if ({rsp_id, rsp_result, rsp_err} !== 11'h0) begin errors++; $display("[TB] FAIL reset_rsp: got %0h expected 0", {rsp_id, rsp_result, rsp_err}); end
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    drive_req(0, 4'd3, 4'd5, 2'd0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL add_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL add_ready_pulse: got %b expected 0000", req_ready); end
    checks++; if ({alu_a, alu_b, alu_op} !== {4'd3, 4'd5, 2'd0}) begin errors++; $display("[TB] FAIL add_alu_in: got %0h expected %0h", {alu_a, alu_b, alu_op}, {4'd3, 4'd5, 2'd0}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL add_busy: got %0b expected 1", busy); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_early_valid: got %0b expected 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_rsp_valid: got %0b expected 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL add_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (rsp_result !== 8'h08) begin errors++; $display("[TB] FAIL add_result: got %0h expected 08", rsp_result); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL add_done: got valid=%0b busy=%0b expected 0/0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_req(i, 4'd15, 4'd15, 2'd2);
    for (int g = 0; g < 5; g++) begin
      exp_rdy = 4'b0001 << (g % 4);
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", g, req_ready, exp_rdy); end
      tick();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rr_busy_ready%0d: got %b expected 0000", g, req_ready); end
      tick();
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g % 4)) begin errors++; $display("[TB] FAIL rr_rsp%0d: got valid=%0b id=%0d expected 1/%0d", g, rsp_valid, rsp_id, g % 4); end
      checks++; if (rsp_result !== 8'hE1) begin errors++; $display("[TB] FAIL rr_result%0d: got %0h expected e1", g, rsp_result); end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drive_req(2, 4'd3, 4'd5, 2'd1);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL bp_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    drive_req(0, 4'd1, 4'd1, 2'd0);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("[TB] FAIL bp_hold%0d: got valid=%0b id=%0d expected 1/2", c, rsp_valid, rsp_id); end
      checks++; if (rsp_result !== 8'hFE) begin errors++; $display("[TB] FAIL bp_result%0d: got %0h expected fe", c, rsp_result); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_no_grant%0d: got %b expected 0000", c, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got valid=%0b busy=%0b expected 0/0", rsp_valid, busy); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL bp_pending_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 8'h02) begin errors++; $display("[TB] FAIL bp_pending_rsp: got %0b/%0d/%0h expected 1/0/02", rsp_valid, rsp_id, rsp_result); end
    tick();
  endtask

  task automatic test_div0();
    rsp_ready = 1'b1;
    drive_req(1, 4'd9, 4'd0, 2'd3);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL div0_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
`ifdef ALU_DIV0_GUARD_EN
    checks++; if ({alu_a, alu_b, alu_op} !== 10'h0) begin errors++; $display("[TB] FAIL div0_alu_in: got %0h expected 0", {alu_a, alu_b, alu_op}); end
`else
    checks++; if ({alu_a, alu_b, alu_op} !== {4'd9, 4'd0, 2'd3}) begin errors++; $display("[TB] FAIL div0_alu_in: got %0h expected %0h", {alu_a, alu_b, alu_op}, {4'd9, 4'd0, 2'd3}); end
`endif
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("[TB] FAIL div0_rsp: got valid=%0b id=%0d expected 1/1", rsp_valid, rsp_id); end
`ifdef ALU_DIV0_GUARD_EN
    checks++; if (rsp_result !== 8'hFF) begin errors++; $display("[TB] FAIL div0_result: got %0h expected ff", rsp_result); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL div0_err: got %0b expected 1", rsp_err); end
`else
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL div0_err: got %0b expected 0", rsp_err); end
`endif
    tick();
  endtask

  task automatic test_reset_mid_op();
    rsp_ready = 1'b1;
    drive_req(2, 4'd7, 4'd1, 2'd0);
    drive_req(0, 4'd2, 4'd3, 2'd0);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL rst_mid_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_exec: got busy=%0b expected 1", busy); end
    reset = 1'b1;
    tick();
    checks++; if ({alu_a, alu_b, alu_op} !== 10'h0) begin errors++; $display("[TB] FAIL rst_mid_alu: got %0h expected 0", {alu_a, alu_b, alu_op}); end
    checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_err, busy} !== 13'h0) begin errors++; $display("[TB] FAIL rst_mid_rsp: got %0h expected 0", {rsp_valid, rsp_id, rsp_result, rsp_err, busy}); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b expected 0000", req_ready); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rst_mid_regrant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_stale: got %0b expected 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 8'h05) begin errors++; $display("[TB] FAIL rst_mid_rsp0: got %0b/%0d/%0h expected 1/0/05", rsp_valid, rsp_id, rsp_result); end
    tick();
  endtask

  task automatic test_ptr_wrap();
    rsp_ready = 1'b1;
    drive_req(1, 4'd1, 4'd2, 2'd0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_setup: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    drive_req(3, 4'd4, 4'd4, 2'd0);
    drive_req(1, 4'd6, 4'd2, 2'd1);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_first: got %b expected 1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    tick(); tick();
    checks++; if (rsp_id !== 2'd3 || rsp_result !== 8'h08) begin errors++; $display("[TB] FAIL wrap_rsp3: got %0d/%0h expected 3/08", rsp_id, rsp_result); end
    tick();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_second: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick();
    checks++; if (rsp_id !== 2'd1 || rsp_result !== 8'h04) begin errors++; $display("[TB] FAIL wrap_rsp1: got %0d/%0h expected 1/04", rsp_id, rsp_result); end
    tick();
    for (int i = 0; i < 4; i++) drive_req(i, 4'd1, 4'd1, 2'd0);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL wrap_ptr_end: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_div0();
    test_reset_mid_op();
    test_ptr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
